// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency main memory between
// the I-cache and D-cache miss handlers.
//
// Each granted transaction is one of two kinds:
//   - a LINE_WORDS-word line fill (burst read), for either side;
//   - a single-word write-through store, for the D side only.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_req/i_addr         I-side fill request (held until i_done) and byte address
//   i_grant              I side owns the memory
//   i_data/i_valid/i_word/i_done
//                        returned fill word, its strobe, its line index,
//                        and a one-cycle completion pulse
//   d_req/d_wr/d_addr/d_wdata
//                        D-side request: d_wr=1 is a store, d_wr=0 is a fill
//   d_grant/d_data/d_valid/d_word/d_done
//                        D-side outputs, same meaning as the I side
//   mem_en/mem_wr/mem_addr/mem_wdata
//                        memory access strobe, write enable, byte address, store data
//   mem_rdata/mem_rvalid read return from memory, MEM_LAT cycles after each read
//
// Handshake: a requester raises req and holds it, with address and data
// stable, until its done pulse. The block captures address and store data
// when it grants. It never stalls the memory: one read goes out per cycle,
// and every mem_rvalid seen during a fill is forwarded in the same cycle.
//
// Build option ARB_RR_EN: when defined, simultaneous requests are resolved
// round-robin by a last-owner bit. Otherwise the D side always wins.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int MEM_LAT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic [15:0] i_data,
  output logic        i_valid,
  output logic [3:0]  i_word,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic [15:0] d_data,
  output logic        d_valid,
  output logic [3:0]  d_word,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int              CW        = $clog2(LINE_WORDS);
  // Byte-offset bits inside a line (2 bytes per word).
  localparam logic [15:0]     LINE_MASK = 16'(2 * LINE_WORDS - 1);
  localparam logic [CW-1:0]   LAST_IDX  = CW'(LINE_WORDS - 1);

  generate
    if (LINE_WORDS < 2 || LINE_WORDS > 16 ||
        (LINE_WORDS & (LINE_WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_bad_param
      $error("mem_arbiter: LINE_WORDS must be a power of two in 2..16 and MEM_LAT >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = D side owns, 0 = I side owns
  logic [15:0]   base_q,  base_d;    // line base for fills, word address for stores
  logic [15:0]   wdata_q, wdata_d;
  logic [CW:0]   iss_q,   iss_d;     // MSB set once all reads have gone out
  logic [CW-1:0] ret_q,   ret_d;     // index of the next returning word

  logic d_prio;
  logic pick_d;

`ifdef ARB_RR_EN
  // Last owner: 0 = I, 1 = D. The side that did not win last time gets
  // priority on a tie, so neither can starve the other.
  logic last_q, last_d;
  assign d_prio = ~last_q;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (i_req || d_req)) last_d = pick_d;
  end
`else
  assign d_prio = 1'b1;
`endif

  assign pick_d = d_req && (!i_req || d_prio);

  logic        fill_st, write_st, issuing, ret_v, last_ret;
  logic [15:0] iss_off;

  assign fill_st  = (state_q == FILL);
  assign write_st = (state_q == WRITE);
  assign issuing  = fill_st && !iss_q[CW];
  assign iss_off  = 16'(iss_q[CW-1:0]) << 1;
  // Returns are only meaningful while filling; stale ones after reset or
  // during a store are dropped here.
  assign ret_v    = fill_st && mem_rvalid;
  assign last_ret = ret_v && (ret_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: begin
        iss_d = '0;
        ret_d = '0;
        if (pick_d) begin
          owner_d = 1'b1;
          if (d_wr) begin
            state_d = WRITE;
            base_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            state_d = FILL;
            base_d  = d_addr & ~LINE_MASK;
          end
        end else if (i_req) begin
          owner_d = 1'b0;
          state_d = FILL;
          base_d  = i_addr & ~LINE_MASK;
        end
      end
      FILL: begin
        if (issuing) iss_d = iss_q + 1'b1;
        if (ret_v)   ret_d = ret_q + 1'b1;
        if (last_ret) state_d = IDLE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
`ifdef ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Memory side
  assign mem_en    = issuing || write_st;
  assign mem_wr    = write_st;
  assign mem_addr  = issuing ? (base_q + iss_off) : (write_st ? base_q : 16'h0000);
  assign mem_wdata = write_st ? wdata_q : 16'h0000;

  // Requester side: grant spans the first issue cycle through done.
  assign i_grant = fill_st && !owner_q;
  assign d_grant = (fill_st && owner_q) || write_st;

  assign i_valid = ret_v && !owner_q;
  assign i_data  = i_valid ? mem_rdata : 16'h0000;
  assign i_word  = i_valid ? 4'(ret_q) : 4'h0;
  assign i_done  = last_ret && !owner_q;

  assign d_valid = ret_v && owner_q;
  assign d_data  = d_valid ? mem_rdata : 16'h0000;
  assign d_word  = d_valid ? 4'(ret_q) : 4'h0;
  assign d_done  = (last_ret && owner_q) || write_st;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a fixed-latency memory
// model and scoreboard queues for memory accesses and per-side fill returns.
module tb_mem_arbiter;

  localparam int LINE_WORDS = 8;
  localparam int MEM_LAT    = 4;
  localparam int FILL_CYC   = LINE_WORDS + MEM_LAT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_valid, i_done, d_grant, d_valid, d_done;
  logic [15:0] i_data, d_data;
  logic [3:0]  i_word, d_word;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_mem_q[$];  // {wr, addr, wdata}
  logic [19:0] exp_i_q[$];    // {word, data}
  logic [19:0] exp_d_q[$];

  mem_arbiter #(.LINE_WORDS(LINE_WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
    .i_valid(i_valid), .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data(d_data), .d_valid(d_valid), .d_word(d_word),
    .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (not reset: stale returns survive reset) ----
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  logic        pv [MEM_LAT];
  logic [15:0] pa [MEM_LAT];

  initial for (int s = 0; s < MEM_LAT; s++) begin pv[s] = 1'b0; pa[s] = 16'h0; end

  always @(posedge clk) begin
    for (int s = MEM_LAT - 1; s > 0; s--) begin
      pv[s] <= pv[s-1];
      pa[s] <= pa[s-1];
    end
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
  end

  assign mem_rvalid = pv[MEM_LAT-1];
  assign mem_rdata  = pv[MEM_LAT-1] ? mem_val(pa[MEM_LAT-1]) : 16'h0000;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [79:0] all_outs;
  assign all_outs = {i_grant, i_data, i_valid, i_word, i_done,
                     d_grant, d_data, d_valid, d_word, d_done,
                     mem_en, mem_wr, mem_addr, mem_wdata};

  // Scoreboard: every memory access and every returned word must match the
  // next expected entry pushed by the stimulus.
  always @(negedge clk) begin
    if (mem_en) begin
      check("mem_pending", 128'(exp_mem_q.size() != 0), 128'd1);
      if (exp_mem_q.size() != 0)
        check("mem_access", {mem_wr, mem_addr, mem_wdata}, exp_mem_q.pop_front());
    end
    if (i_valid) begin
      check("i_pending", 128'(exp_i_q.size() != 0), 128'd1);
      if (exp_i_q.size() != 0) check("i_ret", {i_word, i_data}, exp_i_q.pop_front());
    end
    if (d_valid) begin
      check("d_pending", 128'(exp_d_q.size() != 0), 128'd1);
      if (exp_d_q.size() != 0) check("d_ret", {d_word, d_data}, exp_d_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_fill(input logic d_own, input logic [15:0] addr);
    logic [15:0] base, a;
    base = addr & ~16'(2 * LINE_WORDS - 1);
    for (int k = 0; k < LINE_WORDS; k++) begin
      a = base + 16'(2 * k);
      exp_mem_q.push_back({1'b0, a, 16'h0000});
      if (d_own) exp_d_q.push_back({4'(k), mem_val(a)});
      else       exp_i_q.push_back({4'(k), mem_val(a)});
    end
  endtask

  // Checks cycles 1..FILL_CYC of a fill. At cycle drop_at (0 = never) the
  // owner's request is dropped and its address scrambled.
  task automatic fill_window(input logic d_own, input int drop_at);
    for (int c = 1; c <= FILL_CYC; c++) begin
      tick();
      check("grant",  {i_grant, d_grant}, d_own ? 2'b01 : 2'b10);
      check("issue",  mem_en, c <= LINE_WORDS);
      check("valid",  d_own ? d_valid : i_valid, c > MEM_LAT);
      check("i_done", i_done, !d_own && c == FILL_CYC);
      check("d_done", d_done, d_own && c == FILL_CYC);
      if (c == drop_at) begin
        if (d_own) begin d_req = 1'b0; d_addr = 16'($urandom); end
        else       begin i_req = 1'b0; i_addr = 16'($urandom); end
      end
    end
  endtask

  task automatic idle_cycle();
    tick();
    check("idle_grant", {i_grant, d_grant}, 2'b00);
    check("idle_mem",   mem_en, 1'b0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    exp_mem_q.push_back({1'b1, addr, data});
    d_req = 1'b1; d_wr = 1'b1; d_addr = addr; d_wdata = data;
    tick();
    check("wr_done",  {d_done, d_grant, i_grant, mem_wr}, 4'b1101);
    d_req = 1'b0; d_wr = 1'b0; d_wdata = 16'($urandom);
    tick();
    check("wr_after", {d_done, d_grant, mem_en}, 3'b000);
  endtask

  // ---------------- directed sequence ----------------
  logic [2:0] order;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    tick(); tick();
    check("reset_outs", all_outs, 80'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_outs", all_outs, 80'h0);

    // Simultaneous fills: D first, I granted two cycles after d_done.
    d_addr = 16'h4000; i_addr = 16'h4000; d_wr = 1'b0;
    push_fill(1'b1, 16'h4000);
    push_fill(1'b0, 16'h4000);
    i_req = 1'b1; d_req = 1'b1;
    fill_window(1'b1, FILL_CYC);
    idle_cycle();
    fill_window(1'b0, FILL_CYC);
    idle_cycle();

    // Both sides keep requesting: fixed priority gives D,D,D then I;
    // round-robin alternates D,I,D.
`ifdef ARB_RR_EN
    order = 3'b101;
`else
    order = 3'b111;
`endif
    d_addr = 16'h4000; i_addr = 16'h1100;
    for (int g = 0; g < 3; g++) push_fill(order[g], order[g] ? 16'h4000 : 16'h1100);
`ifndef ARB_RR_EN
    push_fill(1'b0, 16'h1100);
`endif
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      fill_window(order[g], (g == 2 || !order[g]) ? FILL_CYC : 0);
      idle_cycle();
    end
`ifndef ARB_RR_EN
    fill_window(1'b0, FILL_CYC);
    idle_cycle();
`endif

    // Plain I fill from an unaligned address.
    i_addr = 16'h0136;
    push_fill(1'b0, 16'h0136);
    i_req = 1'b1;
    fill_window(1'b0, FILL_CYC);
    idle_cycle();

    // Single-word store.
    do_write(16'h2002, 16'hBEEF);

    // Reset in the middle of an I fill; stale returns keep arriving.
    i_addr = 16'h0A46;
    for (int k = 0; k < 5; k++) exp_mem_q.push_back({1'b0, 16'h0A40 + 16'(2 * k), 16'h0000});
    exp_i_q.push_back({4'd0, mem_val(16'h0A40)});
    i_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("rst_pre_grant", i_grant, 1'b1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; i_req = 1'b0;
    tick();
    check("rst_mid_outs", all_outs, 80'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("rst_rel_outs", all_outs, 80'h0);
    tick();
    check("rst_idle_outs", all_outs, 80'h0);
    do_write(16'h3A5C, 16'h1234);
    tick();
    check("rst_drain_outs", all_outs, 80'h0);

    // Back-to-back D fills with d_req held.
    d_addr = 16'h5550;
    push_fill(1'b1, 16'h5550);
    push_fill(1'b1, 16'h5550);
    d_req = 1'b1;
    fill_window(1'b1, 0);
    idle_cycle();
    fill_window(1'b1, FILL_CYC);
    idle_cycle();

    // Random stores.
    for (int n = 0; n < 4; n++)
      do_write(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));

    // Request dropped and address changed mid-fill: fill still completes.
    i_addr = 16'h7A5E;
    push_fill(1'b0, 16'h7A5E);
    i_req = 1'b1;
    fill_window(1'b0, 2);
    idle_cycle();
    idle_cycle();

    check("sb_empty", 128'(exp_mem_q.size() + exp_i_q.size() + exp_d_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
